// File: rtl/hs_pkg.sv
// Shared types for the req/ack transmitter family.
// FSM state encoding and timeout counter sizing helper.
package hs_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        REL  = 2'd2,
        ERR  = 2'd3
    } hs_state_t;

    // Width of a counter that must be able to hold tc
    function automatic int hs_cnt_w(input int tc);
        return (tc < 2) ? 1 : $clog2(tc + 1);
    endfunction

endpackage

// File: rtl/hs_sync.sv
// Multi-flop synchroniser with async active-low clear.
// Shared by the transmitter and receiver sides of the link.
module hs_sync #(
    parameter int STAGES = 2,
    parameter int W      = 1
) (
    input  logic         clk,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] ff [STAGES];

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            for (int i = 0; i < STAGES; i++)
                ff[i] <= '0;
        end else begin
            ff[0] <= d;
            for (int i = 1; i < STAGES; i++)
                ff[i] <= ff[i-1];
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/hs_tx_fifo.sv
// 4-phase req/ack transmitter draining a small word FIFO.
// Optional ack timeout: define HS_TX_TIMEOUT_EN.
module hs_tx_fifo
    import hs_pkg::*;
#(
    parameter int DATA_W      = 6,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                   clk,
    input  logic                   clr,
    input  logic                   en,
    input  logic                   wr_valid,
    input  logic [DATA_W-1:0]      wr_data,
    output logic                   wr_ready,
    input  logic                   ack,
    output logic                   req,
    output logic [DATA_W-1:0]      data_out,
    output logic [$clog2(DEPTH):0] count,
    output logic                   err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    hs_state_t   state, nxt;
    logic        ack_s;
    logic        start, pop, req_d, tmo;
    logic        full, push;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] cnt;
    logic [DATA_W-1:0] mem [DEPTH];

    hs_sync #(.STAGES(SYNC_STAGES), .W(1)) u_sync (
        .clk (clk),
        .clr (clr),
        .d   (ack),
        .q   (ack_s)
    );

    assign full     = (cnt == CW'(DEPTH));
    assign push     = wr_valid && !full;
    assign wr_ready = !full;
    assign count    = cnt;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) state <= IDLE;
        else      state <= nxt;
    end

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE: if (en && cnt != '0 && !ack_s) nxt = REQ;
            REQ:  if (ack_s) nxt = REL;
                  else if (tmo) nxt = ERR;
            REL:  if (!ack_s) nxt = IDLE;
                  else if (tmo) nxt = ERR;
            ERR:  nxt = ERR;
            default: nxt = IDLE;
        endcase
    end

    always_comb begin
        start = (state == IDLE) && (nxt == REQ);
        pop   = (state == REQ) && (nxt == REL);
        req_d = (nxt == REQ);
    end

`ifdef HS_TX_TIMEOUT_EN
    localparam int TW = hs_cnt_w(TIMEOUT_CYC);
    logic [TW-1:0] wcnt;
    logic          busy;

    assign busy = (state == REQ) || (state == REL);
    assign tmo  = busy && (wcnt == TW'(TIMEOUT_CYC - 1));
    assign err  = (state == ERR);

    // Restart the wait on every state change
    always_ff @(posedge clk or negedge clr) begin
        if (!clr)               wcnt <= '0;
        else if (state != nxt)  wcnt <= '0;
        else if (busy)          wcnt <= wcnt + 1'b1;
    end
`else
    logic unused_tmo;
    assign unused_tmo = ^TIMEOUT_CYC;
    assign tmo        = 1'b0;
    assign err        = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            req      <= 1'b0;
            data_out <= '0;
        end else begin
            req <= req_d;
            if (start) data_out <= mem[rd_ptr];
        end
    end

endmodule

// File: tb/tb_hs_tx_fifo.sv
// Directed self-checking bench for hs_tx_fifo.
module tb_hs_tx_fifo;

    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic       en = 1'b0;
    logic       wr_valid = 1'b0;
    logic [5:0] wr_data = '0;
    logic       wr_ready;
    logic       ack = 1'b0;
    logic       req;
    logic [5:0] data_out;
    logic [2:0] count;
    logic       err;

    int tests = 0;
    int fails = 0;

    hs_tx_fifo #(
        .DATA_W(6), .DEPTH(4), .SYNC_STAGES(2), .TIMEOUT_CYC(10)
    ) dut (
        .clk(clk), .clr(clr), .en(en),
        .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
        .ack(ack), .req(req), .data_out(data_out),
        .count(count), .err(err)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic write_word(input logic [5:0] w);
        wr_valid = 1'b1;
        wr_data  = w;
        tick();
        wr_valid = 1'b0;
    endtask

    // Receiver: wait for req, ack it, wait for req to drop, release ack
    task automatic serve(output logic [5:0] w, output bit ok);
        ok = 1'b0;
        w  = '0;
        for (int i = 0; i < 40 && req !== 1'b1; i++) tick();
        if (req !== 1'b1) return;
        w   = data_out;
        ack = 1'b1;
        for (int i = 0; i < 40 && req !== 1'b0; i++) tick();
        ack = 1'b0;
        if (req !== 1'b0) return;
        ok = 1'b1;
    endtask

    task automatic test_reset;
        #2;
        tests++;
        if (req !== 1'b0) begin
            fails++; $display("FAIL rst_req got %b exp 0", req);
        end
        tests++;
        if (data_out !== 6'h00) begin
            fails++; $display("FAIL rst_data got %h exp 00", data_out);
        end
        tests++;
        if (count !== 3'd0) begin
            fails++; $display("FAIL rst_count got %0d exp 0", count);
        end
        tests++;
        if (wr_ready !== 1'b1) begin
            fails++; $display("FAIL rst_wr_ready got %b exp 1", wr_ready);
        end
        tests++;
        if (err !== 1'b0) begin
            fails++; $display("FAIL rst_err got %b exp 0", err);
        end
        @(negedge clk);
        clr = 1'b1;
        settle(2);
    endtask

    task automatic test_single;
        en = 1'b1;
        write_word(6'h2A);
        tests++;
        if (count !== 3'd1 || req !== 1'b0) begin
            fails++;
            $display("FAIL single_cnt got cnt=%0d req=%b exp 1/0", count, req);
        end
        tick();
        tests++;
        if (req !== 1'b1 || data_out !== 6'h2A) begin
            fails++;
            $display("FAIL single_req got req=%b d=%h exp 1/2a", req, data_out);
        end
        settle(2);
        ack = 1'b1;
        settle(2);
        tests++;
        if (req !== 1'b1) begin
            fails++; $display("FAIL single_hold got %b exp 1", req);
        end
        tick();
        tests++;
        if (req !== 1'b0 || count !== 3'd0) begin
            fails++;
            $display("FAIL single_fall got req=%b cnt=%0d exp 0/0", req, count);
        end
        ack = 1'b0;
        settle(5);
        tests++;
        if (req !== 1'b0 || data_out !== 6'h2A) begin
            fails++;
            $display("FAIL single_idle got req=%b d=%h exp 0/2a", req, data_out);
        end
    endtask

    task automatic test_full;
        logic [5:0] w;
        bit ok;
        en = 1'b1;
        for (int i = 1; i <= 4; i++) write_word(6'(i));
        tests++;
        if (count !== 3'd4 || wr_ready !== 1'b0) begin
            fails++;
            $display("FAIL full_cnt got cnt=%0d rdy=%b exp 4/0", count, wr_ready);
        end
        write_word(6'h05);
        tests++;
        if (count !== 3'd4) begin
            fails++; $display("FAIL full_refuse got %0d exp 4", count);
        end
        for (int i = 1; i <= 4; i++) begin
            serve(w, ok);
            tests++;
            if (!ok || w !== 6'(i)) begin
                fails++;
                $display("FAIL full_word%0d got %h ok=%b exp %h", i, w, ok, 6'(i));
            end
        end
        settle(4);
        tests++;
        if (count !== 3'd0 || wr_ready !== 1'b1) begin
            fails++;
            $display("FAIL full_drain got cnt=%0d rdy=%b exp 0/1", count, wr_ready);
        end
        ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (req !== 1'b0) ok = 1'b0;
            tick();
        end
        tests++;
        if (!ok) begin
            fails++; $display("FAIL full_no_fifth got req=1 exp 0");
        end
    endtask

    task automatic test_en_low;
        logic [5:0] w;
        bit ok;
        en = 1'b1;
        write_word(6'h11);
        write_word(6'h22);
        en = 1'b0;
        tests++;
        if (req !== 1'b1 || count !== 3'd2 || data_out !== 6'h11) begin
            fails++;
            $display("FAIL en_start got req=%b cnt=%0d d=%h exp 1/2/11", req, count, data_out);
        end
        serve(w, ok);
        tests++;
        if (!ok || w !== 6'h11 || count !== 3'd1) begin
            fails++;
            $display("FAIL en_finish got w=%h ok=%b cnt=%0d exp 11/1/1", w, ok, count);
        end
        ok = 1'b1;
        for (int i = 0; i < 15; i++) begin
            if (req !== 1'b0) ok = 1'b0;
            tick();
        end
        tests++;
        if (!ok) begin
            fails++; $display("FAIL en_hold got req=1 exp 0");
        end
        en = 1'b1;
        serve(w, ok);
        tests++;
        if (!ok || w !== 6'h22) begin
            fails++; $display("FAIL en_resume got w=%h ok=%b exp 22", w, ok);
        end
        settle(4);
        tests++;
        if (count !== 3'd0) begin
            fails++; $display("FAIL en_drain got %0d exp 0", count);
        end
    endtask

    task automatic test_reset_mid;
        bit ok;
        en = 1'b1;
        write_word(6'h31);
        write_word(6'h32);
        write_word(6'h33);
        tests++;
        if (req !== 1'b1 || count !== 3'd3) begin
            fails++;
            $display("FAIL mid_pre got req=%b cnt=%0d exp 1/3", req, count);
        end
        #2 clr = 1'b0;
        #1;
        tests++;
        if (req !== 1'b0 || count !== 3'd0 || data_out !== 6'h00) begin
            fails++;
            $display("FAIL mid_clr got req=%b cnt=%0d d=%h exp 0/0/00", req, count, data_out);
        end
        @(negedge clk);
        clr = 1'b1;
        ok = 1'b1;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (req !== 1'b0 || count !== 3'd0) ok = 1'b0;
        end
        tests++;
        if (!ok) begin
            fails++; $display("FAIL mid_stale got req=%b cnt=%0d exp 0/0", req, count);
        end
    endtask

    task automatic test_timeout;
        en = 1'b1;
        write_word(6'h15);
        tick();
`ifdef HS_TX_TIMEOUT_EN
        settle(9);
        tests++;
        if (req !== 1'b1 || err !== 1'b0) begin
            fails++;
            $display("FAIL tmo_before got req=%b err=%b exp 1/0", req, err);
        end
        tick();
        tests++;
        if (req !== 1'b0 || err !== 1'b1) begin
            fails++;
            $display("FAIL tmo_hit got req=%b err=%b exp 0/1", req, err);
        end
        write_word(6'h16);
        settle(5);
        tests++;
        if (req !== 1'b0 || err !== 1'b1 || count !== 3'd2) begin
            fails++;
            $display("FAIL tmo_sticky got req=%b err=%b cnt=%0d exp 0/1/2", req, err, count);
        end
`else
        settle(300);
        tests++;
        if (req !== 1'b1 || err !== 1'b0) begin
            fails++;
            $display("FAIL tmo_off got req=%b err=%b exp 1/0", req, err);
        end
`endif
        clr = 1'b0;
        #2;
        clr = 1'b1;
        settle(2);
    endtask

    initial begin
        test_reset();
        test_single();
        test_full();
        test_en_low();
        test_reset_mid();
        test_timeout();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/hs_tx_fifo.md
# hs_tx_fifo

Parametrised 4-phase req/ack transmitter with an internal word FIFO; the next generation of the team's single-word handshake sender. A local producer pushes words over a valid/ready port. The block drains them one at a time across a 4-phase req/ack link to an asynchronous receiver. It synchronises the incoming ack and holds data_out stable for the whole transaction.

## Interface
- DATA_W, 6, width of each transferred word
- DEPTH, 4, FIFO depth in words; power of two, at least 2
- SYNC_STAGES, 2, ack synchroniser flops; at least 2
- TIMEOUT_CYC, 255, ack wait limit in cycles; used only with HS_TX_TIMEOUT_EN
- clk  in  1  clock
- clr  in  1  reset, asynchronous, active-low
- en  in  1  active-high; permits new transactions to start
- wr_valid  in  1  producer word valid
- wr_data  in  DATA_W  producer word
- wr_ready  out  1  FIFO can accept a word; equals !full, no combinational path from wr_valid
- ack  in  1  receiver acknowledge; asynchronous to clk
- req  out  1  request to receiver; registered
- data_out  out  DATA_W  word on the link; registered
- count  out  $clog2(DEPTH)+1  FIFO occupancy
- err  out  1  sticky ack timeout; constant 0 without the macro

## Operation
- FIFO write: wr_valid && wr_ready at a clk edge stores wr_data and increments count. A write is refused while full, even if a pop happens in the same cycle.
- The FIFO pop happens at the REQ to REL transition. The write and pop pointers wrap modulo DEPTH. count tracks simultaneous write and pop correctly, so occupancy does not change.
- ack_s is ack after SYNC_STAGES flops; the FSM sees only ack_s.
- FSM states: IDLE, REQ, REL, ERR.
  - IDLE to REQ when en && count!=0 && !ack_s. On that edge data_out takes the FIFO head and req is set to 1.
  - REQ to REL when ack_s==1. On that edge req is set to 0 and the head is popped.
  - REL to IDLE when ack_s==0.
  - ERR: reached only with the macro. It is left only by reset.
- data_out changes only on IDLE to REQ edges. It holds its value otherwise, including in IDLE after a transfer.
- en low does not abort a transaction in progress. The FSM completes REQ/REL and then stays in IDLE. FIFO writes continue while en is low.
- If ack_s is high in IDLE, a protocol violation by the receiver, the FSM stays in IDLE until ack_s is low.

## Timing
- Reset values: req=0, data_out=0, count=0, wr_ready=1, err=0, state IDLE, pointers 0, synchroniser flops 0.
- Latency from write to request, with en high and link idle:
  - A word written at edge N is counted after edge N.
  - req rises at edge N+1, with data_out valid on that same edge.
- Link round trip: req falls SYNC_STAGES+1 edges after ack rises (one edge if ack rises just before an edge). The next req can rise one edge after the state returns to IDLE.
- Back-to-back throughput is at most one word per (2·SYNC_STAGES+3) cycles with a zero-delay receiver.
- clr asserted mid-transaction forces req=0 immediately and empties the FIFO. The receiver must tolerate req dropping before it asserts ack.

## Configuration
- Macro: HS_TX_TIMEOUT_EN.
- With the macro: a wait counter clears on entry to REQ or REL and increments every cycle in those states. When it reaches TIMEOUT_CYC, the FSM goes to ERR, req=0, and err=1 (sticky).
  - In ERR, no further transactions start. FIFO writes are still accepted until full. Only clr recovers.
- Without the macro: no counter, ERR is unreachable, err is tied 0, and TIMEOUT_CYC is ignored.

## Structure
- Package hs_pkg:
  - hs_state_t enum (IDLE, REQ, REL, ERR)
  - HS_CNT_W function/constant for the timeout counter width derived from TIMEOUT_CYC
- Sub-module hs_sync: parametrised SYNC_STAGES flop chain on ack with async active-low clear. It is reused for the receiver side later.
- FIFO storage, pointers and FSM live in hs_tx_fifo itself.

## Test plan
- Reset check: after clr release, req=0, data_out=0, count=0, wr_ready=1, err=0.
- Single word, DATA_W=6, receiver acks 3 cycles after req:
  - Write 6'h2A at edge N.
  - req=1 and data_out=6'h2A after edge N+1.
  - req=0 SYNC_STAGES+1 edges after ack rises; count back to 0.
- Full FIFO, DEPTH=4, receiver stalled:
  - Write 6'h01..6'h05. The fifth write is refused (wr_ready=0), count=4.
  - Release the receiver: words 01, 02, 03, 04 go out in order and the pointers wrap.
- en low with FIFO holding 2 words and req high:
  - The current handshake completes.
  - No new req while en=0. Raising en sends the remaining word.
- Reset mid-transaction (REQ state, count=3): clr low gives req=0 immediately and count=0. No stale word is sent after release.
- Timeout, with HS_TX_TIMEOUT_EN and TIMEOUT_CYC=10, ack held low:
  - err=1 and req=0 after 10 cycles in REQ, and they stay that way.
  - Without the macro, req remains 1 indefinitely.
